uart_rx_deserializer: RTL
=========================

Name: uart_rx_deserializer

Overview:
- Receive front end feeding the AHBUart register block.
- Synchronizes the asynchronous rx pin and detects start bits with 16x oversampling.
- Deserializes LSB-first frames (start, data, optional parity, one stop bit).
- Presents each byte to the register block through a valid/ready holding register, with frame-error and sticky overrun status.

Parameters:
- DIV_WIDTH, 16, width of baud divisor input.
- DATA_BITS, 8, data bits per frame (5..8).
- OVERSAMPLE, 16, sample ticks per bit; must be an even power of two.

Ports:
- clk  input  1  system clock
- nReset  input  1  asynchronous active-low reset
- rx  input  1  serial line, asynchronous, idle high
- enable  input  1  receiver enable
- baud_div  input  DIV_WIDTH  one sample tick every baud_div+1 clocks
- rx_data  output  DATA_BITS  received byte
- rx_valid  output  1  rx_data holds an unconsumed byte
- rx_ready  input  1  consumer accepts the byte on rx_valid&&rx_ready
- frame_err  output  1  stop bit of the held byte sampled low
- parity_err  output  1  parity mismatch on the held byte (0 when feature is compiled out)
- overrun  output  1  sticky: a completed byte was dropped
- overrun_clr  input  1  clears overrun
- busy  output  1  frame reception in progress

Behaviour:
- Reset (async, nReset low):
  - Sync flops reset to 1; state is IDLE; all counters are 0.
  - rx_data=0; rx_valid, frame_err, parity_err, overrun and busy are 0.
- Synchronizer: two-flop synchronizer on rx. All decisions use the synchronized value rxs (2-cycle latency).
- Tick generator:
  - div_cnt counts 0..baud_div while enable=1; tick=1 for one clock when div_cnt==baud_div, then div_cnt wraps to 0.
  - baud_div=0 gives a tick every clock.
  - A baud_div change takes effect at the next wrap.
- State machine (advances only on tick unless noted); sample counter scnt:
  - IDLE: rxs==0 -> START, scnt=0.
  - START: at scnt==OVERSAMPLE/2-1, sample rxs. 0 -> DATA, scnt=0, bitcnt=0. 1 -> IDLE (glitch rejected, nothing reported).
  - DATA: at scnt==OVERSAMPLE-1, shift rxs into shreg MSB-first-in so the result is LSB-first on the line; bitcnt++. After DATA_BITS samples -> PARITY if compiled in, else STOP.
  - PARITY: sample at scnt==OVERSAMPLE-1, compare against even parity over the data bits -> STOP.
  - STOP: sample at scnt==OVERSAMPLE-1.
    - rxs==1 -> IDLE.
    - rxs==0 -> BREAK (frame_err for this byte).
    - In both cases, perform completion (below).
  - BREAK: wait for rxs==1 (checked every clock, not on tick) -> IDLE. No start detection while in BREAK.
- Completion (the clock after the stop sample):
  - Holding register free, or rx_valid&&rx_ready in the same cycle: load rx_data, frame_err and parity_err; rx_valid=1. No overrun.
  - Otherwise: drop the new byte, set overrun, leave rx_data and its flags unchanged.
- Handshake:
  - rx_valid stays high until rx_valid&&rx_ready.
  - rx_valid falls the cycle after a transfer unless a new completion coincides.
  - frame_err and parity_err describe the held byte only.
- Overrun:
  - overrun_clr clears overrun.
  - A simultaneous set and clear leaves overrun=1.
- enable:
  - enable=0 forces state to IDLE and zeroes div_cnt, scnt and bitcnt; a partial frame is discarded.
  - The holding register, rx_valid and overrun are kept.
- busy = (state != IDLE).
- Latency: rx_valid rises 1 clock after the stop-bit sample tick.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is present; frames are 1 start + DATA_BITS data + 1 even parity + 1 stop.
  - parity_err reflects the parity check for the held byte.
- Undefined:
  - No PARITY state; frames are 1 start + DATA_BITS data + 1 stop.
  - parity_err is tied to 0.

Test Plan:
- Basic frame: baud_div=0, enable=1, drive frame 0xA5 at 16 clk/bit, rx_ready=0 -> rx_valid=1, rx_data=0xA5, frame_err=0. Pulse rx_ready -> rx_valid=0 next cycle.
- Glitch rejection: rx low for 4 ticks, then high -> state returns to IDLE, busy drops, rx_valid stays 0.
- Framing error and break: send 0x3C with stop bit low, hold rx low 40 clks -> rx_valid=1, rx_data=0x3C, frame_err=1. No new byte until rx returns high; a following 0x11 is received cleanly.
- Overrun: send 0x01 then 0x02, rx_ready=0 -> rx_data=0x01, overrun=1. Pulse overrun_clr -> overrun=0. Repeat with rx_ready=1 at the completion cycle -> 0x02 loads, no overrun.
- Reset/enable mid-frame: assert nReset=0 during bit 3 -> all outputs 0 immediately. Deassert enable mid-frame -> busy=0, no byte. Next full 0x5A frame is received correctly.
- Parity (UART_RX_PARITY_EN defined): 0x07 with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1, rx_data=0x07.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: UART receive front end for the AHBUart register block.
// Two-flop rx synchronizer, baud tick divider, 16x-oversampled start detection,
// LSB-first deserializer and a valid/ready holding register with frame error
// and sticky overrun status.
// Optional even-parity support is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_deserializer #(
  parameter int DIV_WIDTH  = 16,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 rx,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state;
  logic                 rx_meta, rxs;
  logic [DIV_WIDTH-1:0] div_cnt, div_lat;
  logic                 tick;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_done;
  logic                 new_perr;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Sample tick divider; the divisor is latched at each wrap so a change
  // mid-period never truncates or stretches the current period
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      div_cnt <= '0;
      div_lat <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
      div_lat <= baud_div;
    end else if (tick) begin
      div_cnt <= '0;
      div_lat <= baud_div;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = enable && (div_cnt == div_lat);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
`endif

  // Frame state machine: start qualification, data shift, parity, stop, break
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state  <= S_IDLE;
      scnt   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else if (!enable) begin
      state  <= S_IDLE;
      scnt   <= '0;
      bitcnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tick && !rxs) begin
            state <= S_START;
            scnt  <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            if (scnt == S_MID) begin
              // mid-start re-check rejects short glitches silently
              scnt   <= '0;
              bitcnt <= '0;
              state  <= rxs ? S_IDLE : S_DATA;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (scnt == S_END) begin
              scnt   <= '0;
              // first bit on the line ends up in the LSB
              shreg  <= {rxs, shreg[DATA_BITS-1:1]};
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == B_LAST) begin
                bitcnt <= '0;
`ifdef UART_RX_PARITY_EN
                state  <= S_PARITY;
`else
                state  <= S_STOP;
`endif
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            if (scnt == S_END) begin
              scnt    <= '0;
              par_bit <= rxs;
              state   <= S_STOP;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (scnt == S_END) begin
              scnt  <= '0;
              // a low stop bit means a break; hold off until the line rises
              state <= rxs ? S_IDLE : S_BREAK;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stop_done = tick && (state == S_STOP) && (scnt == S_END);
  assign busy      = (state != S_IDLE);

`ifdef UART_RX_PARITY_EN
  // even parity: the parity bit must equal the XOR of the data bits
  assign new_perr = par_bit ^ (^shreg);
`else
  assign new_perr = 1'b0;
`endif

  // Holding register: loads on completion when free or being drained
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else if (stop_done && (!rx_valid || rx_ready)) begin
      rx_data    <= shreg;
      rx_valid   <= 1'b1;
      frame_err  <= !rxs;
      parity_err <= new_perr;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  // Sticky overrun; a set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      overrun <= 1'b0;
    end else if (stop_done && rx_valid && !rx_ready) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule
